// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
// Holds the opcode constants, the alu_op codes, the state encodings,
// the ALU B / PC source select codes and the opcode class enumeration.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SLTI  = 3'b001;
  localparam logic [2:0] ALU_ANDI  = 3'b010;
  localparam logic [2:0] ALU_ORI   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b100;
  localparam logic [2:0] ALU_BEQ   = 3'b101;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_IMM    = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_BEQ,
    CLS_IMM,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/main_control_fsm_opcode_class.sv
// Combinational opcode classifier shared by DECODE (dispatch) and IMM
// (ALU operation of the immediate instruction).
// Ports: opcode (in, 6) ; op_class (out) ; imm_alu_op (out, 3) ; legal (out, 1)
module opcode_class
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu_op,
  output logic       legal
);

  always_comb begin
    op_class   = CLS_ILLEGAL;
    imm_alu_op = ALU_ADD;
    legal      = 1'b1;
    case (opcode)
      OP_LW, OP_SW: op_class = CLS_MEM;
      OP_RTYPE:     op_class = CLS_RTYPE;
      OP_BEQ:       op_class = CLS_BEQ;
      OP_J:         op_class = CLS_JUMP;
      OP_ADDI:      op_class = CLS_IMM;
      OP_SLTI: begin op_class = CLS_IMM; imm_alu_op = ALU_SLTI; end
      OP_ANDI: begin op_class = CLS_IMM; imm_alu_op = ALU_ANDI; end
      OP_ORI:  begin op_class = CLS_IMM; imm_alu_op = ALU_ORI;  end
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch, decode, execute,
// memory and write-back, and drives all datapath enables and mux selects.
// Ports:
//   clk, rst (sync, active-high) ; opcode[5:0] ; zero ; mem_ready
//   pc_write, ir_write, mem_read, mem_write, reg_write : enables
//   i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source[1:0]
//   alu_op[2:0] ; state[ST_W-1:0] ; illegal_op (sticky) ; instr_count
module main_control_fsm
  import mips_pkg::*;
#(
  parameter int ST_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             i_or_d,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_op,
  output logic [ST_W-1:0]  state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             retire, illegal_set;

  op_class_t        op_class;
  logic [2:0]       imm_alu_op;
  logic             legal;

  opcode_class u_opcode_class (
    .opcode     (opcode),
    .op_class   (op_class),
    .imm_alu_op (imm_alu_op),
    .legal      (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (retire)      count_q   <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    retire      = 1'b0;
    illegal_set = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    pc_source   = PCSRC_ALU;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target while dispatching.
        alu_src_b   = SRCB_IMM_SH2;
        illegal_set = !legal;
        case (op_class)
          CLS_MEM:   state_d = S_MEMADR;
          CLS_RTYPE: state_d = S_RTYPE;
          CLS_BEQ:   state_d = S_BEQ;
          CLS_IMM:   state_d = S_IMM;
          CLS_JUMP:  state_d = S_JUMP;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        // A store retires on the cycle its memory access completes.
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_BEQ;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
        retire    = 1'b1;
      end
      S_IMM: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    // No datapath write or access may escape while reset is held.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state       = ST_W'(state_q);
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule
